seed_round_ctrl: RTL and testbench
==================================

# seed_round_ctrl

Round sequencer for the SEED block-cipher core. Accepts one block request at a time through a valid/ready handshake and drives the round datapath and key schedule through 16 rounds. Each round is split into 4 clock-enabled phases. The block also generates the `sync` phase strobe that the round registers use, and ends each request with an output-valid handshake. It sits between the host-side block interface and the SEED round/key-schedule datapath.

## Interface
- `NUM_ROUNDS`, default 16: rounds per block; range 2..16.
- `PHASE_W`, default 2: phase counter width; phases per round = 2**PHASE_W.

- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clk_en` in 1: clock enable; gates every state, counter and handshake update.
- `abort` in 1: synchronous abort; sampled when `clk_en`=1.
- `req_valid` in 1: host block request.
- `req_decrypt` in 1: mode for the request; 1 = decrypt. Sampled when the request is accepted.
- `req_ready` out 1: controller idle and able to accept a request.
- `load_block` out 1: datapath loads the input block.
- `load_key` out 1: key schedule loads the user key.
- `round_en` out 1: datapath commits the current round.
- `key_step` out 1: key schedule advances to the next round key.
- `key_dir` out 1: 0 = forward key order, 1 = reverse.
- `round_idx` out 4: current round number, used as the KC constant index.
- `phase` out PHASE_W: phase within the round.
- `sync` out 1: phase strobe, equal to `phase[0]` while in ROUND.
- `busy` out 1: state is LOAD or ROUND.
- `out_valid` out 1: result block is valid.
- `out_ready` in 1: consumer accepts the result.

## Operation
- States are IDLE, LOAD, ROUND and DONE. Nothing changes on any edge where `clk_en`=0.
- IDLE
  - `req_ready`=1.
  - When `req_valid`=1 the request is accepted: `key_dir` is latched from `req_decrypt` and the state moves to LOAD.
- LOAD
  - `load_block`=1 and `load_key`=1 for one enabled cycle.
  - Next state is ROUND with `phase`=0.
  - `round_idx` is set to 0 for encrypt, or NUM_ROUNDS-1 for decrypt.
- ROUND
  - `phase` increments on each enabled edge.
  - At the last phase, `round_en`=1.
  - If this is not the final round, `key_step`=1 at the same time. On that edge `phase` wraps to 0 and `round_idx` moves by +1 (encrypt) or -1 (decrypt).
  - The final round is index NUM_ROUNDS-1 for encrypt and 0 for decrypt. On its last phase, `round_en`=1, `key_step`=0, and the next state is DONE.
- DONE
  - `out_valid`=1 until `out_ready`=1 on an enabled edge, then the state returns to IDLE.
  - `req_valid` is ignored in DONE.
- Abort
  - `abort`=1 on an enabled edge forces IDLE from any state and clears `phase`, `round_idx` and `key_dir`.
  - No `out_valid` pulse is produced for the aborted request.
  - Abort has priority over every other transition, including acceptance in IDLE and `out_ready` in DONE.
- Output decoding: all outputs are decoded from registered state only; there is no input-to-output combinational path.
- Width rules: `round_idx` is 4 bits and never leaves the range 0..NUM_ROUNDS-1. `phase` is a modulo-2**PHASE_W counter.

## Timing
- Reset values: state IDLE; `phase`=0, `round_idx`=0, `key_dir`=0, `sync`=0, `busy`=0, `out_valid`=0, `load_block`=0, `load_key`=0, `round_en`=0, `key_step`=0; `req_ready`=1.
- Latency with `clk_en` held at 1, for a request accepted at edge t0:
  - `load_block` is high between edges t0 and t0+1.
  - Round r phase p occupies the cycle after edge t0+1+4r+p.
  - `out_valid` rises after edge t0+1+NUM_ROUNDS·4, which is t0+65 at the defaults.
- With gaps in `clk_en`, latency counts enabled edges only. Outputs hold their values across disabled cycles.
- Back-to-back operation: the edge where `out_ready` is accepted moves the state to IDLE. The next request can be accepted at the following enabled edge, giving a minimum gap of 1 idle cycle.
- A `reset` assertion mid-operation clears all state immediately, without waiting for a clock edge.

## Configuration
- Macro `SEED_ROUND_CTRL_DECRYPT_EN`.
- Defined: `req_decrypt` selects reverse round order and reverse key order, as described in Operation.
- Undefined:
  - `req_decrypt` is ignored and `key_dir` is tied to 0.
  - `round_idx` always counts up from 0.
  - The decrement logic is not built.

## Test plan
- Reset, then an encrypt request at t0 with `clk_en`=1 → `load_block` high for 1 cycle; `round_idx` runs 0..15; 16 `round_en` pulses and 15 `key_step` pulses; `out_valid` after edge t0+65.
- Decrypt request (macro defined) → `key_dir`=1 and `round_idx` runs 15..0. With the macro undefined, the same stimulus gives `key_dir`=0 and ascending indices.
- `clk_en` toggling 1/0 every cycle during an encrypt → identical output sequence stretched to 2× length; outputs hold during disabled cycles.
- `abort` at round 7 phase 2 → IDLE on that edge, `req_ready`=1, and no `out_valid`. A new request accepted next is processed with full 65-edge latency.
- `out_ready` held low for 10 cycles in DONE with `req_valid`=1 → `out_valid` held and the request not accepted. Releasing `out_ready` gives IDLE, then acceptance at the next enabled edge.
- Asynchronous `reset` pulse mid-ROUND between clock edges → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/seed_round_ctrl_if.sv
// Handshake and datapath-control bundle between seed_round_ctrl (master) and
// the host block interface / SEED round datapath (slave).
interface seed_round_ctrl_if #(
    parameter int PHASE_W = 2
);
    logic               req_valid;
    logic               req_decrypt;
    logic               req_ready;
    logic               load_block;
    logic               load_key;
    logic               round_en;
    logic               key_step;
    logic               key_dir;
    logic [3:0]         round_idx;
    logic [PHASE_W-1:0] phase;
    logic               sync;
    logic               busy;
    logic               out_valid;
    logic               out_ready;

    modport master (
        input  req_valid, req_decrypt, out_ready,
        output req_ready, load_block, load_key, round_en, key_step, key_dir,
               round_idx, phase, sync, busy, out_valid
    );

    modport slave (
        output req_valid, req_decrypt, out_ready,
        input  req_ready, load_block, load_key, round_en, key_step, key_dir,
               round_idx, phase, sync, busy, out_valid
    );
endinterface

// File: rtl/seed_round_ctrl.sv
// SEED round sequencer: IDLE -> LOAD -> ROUND x NUM_ROUNDS -> DONE, clock-enabled.
// Define SEED_ROUND_CTRL_DECRYPT_EN to build reverse round/key order for decrypt.
module seed_round_ctrl #(
    parameter int NUM_ROUNDS = 16,
    parameter int PHASE_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              abort,
    seed_round_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

    localparam logic [3:0]         LAST_IDX  = 4'(NUM_ROUNDS - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE = 1;

    state_t             state_q;
    state_t             state_d;
    logic [PHASE_W-1:0] phase_q;
    logic [3:0]         round_idx_q;
    logic               key_dir_q;

    logic               last_phase;
    logic               final_round;
    logic               accept_dir;
    logic [3:0]         start_idx;
    logic [3:0]         next_idx;

    assign last_phase = &phase_q;

`ifdef SEED_ROUND_CTRL_DECRYPT_EN
    assign accept_dir  = bus.req_decrypt;
    assign final_round = key_dir_q ? (round_idx_q == 4'd0) : (round_idx_q == LAST_IDX);
    assign start_idx   = key_dir_q ? LAST_IDX : 4'd0;
    assign next_idx    = key_dir_q ? (round_idx_q - 4'd1) : (round_idx_q + 4'd1);
`else
    assign accept_dir  = 1'b0;
    assign final_round = (round_idx_q == LAST_IDX);
    assign start_idx   = 4'd0;
    assign next_idx    = round_idx_q + 4'd1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    // Abort wins over acceptance in IDLE and over out_ready in DONE.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.req_valid) state_d = LOAD;
                LOAD:    state_d = ROUND;
                ROUND:   if (last_phase && final_round) state_d = DONE;
                DONE:    if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q     <= '0;
            round_idx_q <= 4'd0;
            key_dir_q   <= 1'b0;
        end else if (clk_en) begin
            if (abort) begin
                phase_q     <= '0;
                round_idx_q <= 4'd0;
                key_dir_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.req_valid) key_dir_q <= accept_dir;
                    end
                    LOAD: begin
                        phase_q     <= '0;
                        round_idx_q <= start_idx;
                    end
                    ROUND: begin
                        phase_q <= phase_q + PHASE_ONE;
                        if (last_phase && !final_round) round_idx_q <= next_idx;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Every output comes from registered state, so no input reaches an output combinationally.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.load_block = 1'b0;
        bus.load_key   = 1'b0;
        bus.round_en   = 1'b0;
        bus.key_step   = 1'b0;
        bus.sync       = 1'b0;
        bus.busy       = 1'b0;
        bus.out_valid  = 1'b0;
        case (state_q)
            IDLE: bus.req_ready = 1'b1;
            LOAD: begin
                bus.load_block = 1'b1;
                bus.load_key   = 1'b1;
                bus.busy       = 1'b1;
            end
            ROUND: begin
                bus.busy     = 1'b1;
                bus.sync     = phase_q[0];
                bus.round_en = last_phase;
                bus.key_step = last_phase && !final_round;
            end
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.phase     = phase_q;
    assign bus.round_idx = round_idx_q;
    assign bus.key_dir   = key_dir_q;

endmodule

// File: tb/tb_seed_round_ctrl.sv
// Self-checking bench for seed_round_ctrl: a per-request edge-count model checked every
// cycle, plus directed literal checks on latency, pulse counts, abort, hold and reset.
module tb_seed_round_ctrl;

    localparam int NR     = 16;
    localparam int PW     = 2;
    localparam int PHASES = 4;
`ifdef SEED_ROUND_CTRL_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    typedef enum int {M_IDLE, M_ACTIVE, M_DONE} mstate_t;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic clk_en = 1'b0;
    logic abort  = 1'b0;
    logic cmp_en = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    mstate_t m_state = M_IDLE;
    int      m_cnt   = 0;
    bit      m_dir   = 1'b0;
    int      m_idx   = 0;

    seed_round_ctrl_if #(.PHASE_W(PW)) bus ();

    seed_round_ctrl #(
        .NUM_ROUNDS(NR),
        .PHASE_W   (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clk_en(clk_en),
        .abort (abort),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, actual, expected, $time);
        end
    endtask

    // m_cnt counts enabled edges since (and including) the accepting edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state <= M_IDLE;
            m_cnt   <= 0;
            m_dir   <= 1'b0;
            m_idx   <= 0;
        end else if (clk_en) begin
            if (abort) begin
                m_state <= M_IDLE;
                m_dir   <= 1'b0;
                m_idx   <= 0;
            end else begin
                case (m_state)
                    M_IDLE: if (bus.req_valid) begin
                        m_state <= M_ACTIVE;
                        m_cnt   <= 1;
                        m_dir   <= DEC_EN ? bus.req_decrypt : 1'b0;
                    end
                    M_ACTIVE: begin
                        m_cnt <= m_cnt + 1;
                        if (m_cnt + 1 >= 2 + PHASES * NR) m_state <= M_DONE;
                        else m_idx <= m_dir ? (NR - 1 - (m_cnt - 1) / PHASES) : ((m_cnt - 1) / PHASES);
                    end
                    M_DONE: if (bus.out_ready) m_state <= M_IDLE;
                    default: m_state <= M_IDLE;
                endcase
            end
        end
    end

    function automatic logic [14:0] model_vec();
        bit in_load, in_round, re, ks;
        int p, r;
        in_load  = (m_state == M_ACTIVE) && (m_cnt == 1);
        in_round = (m_state == M_ACTIVE) && (m_cnt >= 2);
        p        = in_round ? (m_cnt - 2) % PHASES : 0;
        r        = in_round ? (m_cnt - 2) / PHASES : 0;
        re       = in_round && (p == PHASES - 1);
        ks       = re && (r != NR - 1);
        return {m_state == M_IDLE, in_load, in_load, re, ks, m_dir, 4'(m_idx), 2'(p),
                in_round && (p % 2 == 1), m_state == M_ACTIVE, m_state == M_DONE};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {bus.req_ready, bus.load_block, bus.load_key, bus.round_en, bus.key_step, bus.key_dir,
                bus.round_idx, bus.phase, bus.sync, bus.busy, bus.out_valid};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) check_output("cycle_outputs", 32'(dut_vec()), 32'(model_vec()));
    end

    task automatic apply_stimulus(input bit valid, input bit dec, input bit oready, input bit ab, input bit en);
        bus.req_valid   = valid;
        bus.req_decrypt = dec;
        bus.out_ready   = oready;
        abort           = ab;
        clk_en          = en;
    endtask

    task automatic run_block(input bit dec, input bit toggle, input bit release_out,
                             output int latency, output int rcnt, output int kcnt, output int lcnt,
                             output int first_idx, output int last_idx, output int load_dir);
        int n;
        rcnt = 0; kcnt = 0; lcnt = 0; first_idx = -1; last_idx = -1; load_dir = -1;
        apply_stimulus(1'b1, dec, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 400) begin
            if (bus.round_en) begin
                rcnt++;
                if (first_idx < 0) first_idx = int'(bus.round_idx);
                last_idx = int'(bus.round_idx);
            end
            if (bus.key_step) kcnt++;
            if (bus.load_block) begin
                lcnt++;
                load_dir = int'(bus.key_dir);
            end
            clk_en = toggle ? ~clk_en : 1'b1;
            @(negedge clk);
            n++;
        end
        latency = n - 1;
        clk_en  = 1'b1;
        if (release_out) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, rc, kc, lc, fi, li, ld, ov, rr;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_output("reset_outputs", 32'(dut_vec()), 32'h4000);
        reset  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        run_block(1'b0, 1'b0, 1'b1, lat, rc, kc, lc, fi, li, ld);
        check_output("enc_latency", lat, 65);
        check_output("enc_round_en_pulses", rc, 16);
        check_output("enc_key_step_pulses", kc, 15);
        check_output("enc_load_cycles", lc, 1);
        check_output("enc_first_idx", fi, 0);
        check_output("enc_last_idx", li, 15);
        check_output("enc_back_to_idle", bus.req_ready, 1);

        run_block(1'b1, 1'b0, 1'b1, lat, rc, kc, lc, fi, li, ld);
        check_output("dec_latency", lat, 65);
        check_output("dec_key_dir", ld, DEC_EN ? 1 : 0);
        check_output("dec_first_idx", fi, DEC_EN ? 15 : 0);
        check_output("dec_last_idx", li, DEC_EN ? 0 : 15);
        check_output("dec_key_step_pulses", kc, 15);

        run_block(1'b0, 1'b1, 1'b1, lat, rc, kc, lc, fi, li, ld);
        check_output("gap_latency", lat, 130);
        check_output("gap_round_en_cycles", rc, 32);
        check_output("gap_key_step_cycles", kc, 30);
        check_output("gap_load_cycles", lc, 2);

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (30) @(negedge clk);
        check_output("r7p1_sync", bus.sync, 1);
        @(negedge clk);
        check_output("r7p2_phase", bus.phase, 2);
        check_output("r7p2_idx", bus.round_idx, 7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_idle", {bus.req_ready, bus.busy, bus.round_idx, bus.key_dir}, 7'b1000000);
        ov = 0;
        repeat (80) begin
            @(negedge clk);
            ov += int'(bus.out_valid);
        end
        check_output("abort_no_out_valid", ov, 0);
        run_block(1'b0, 1'b0, 1'b1, lat, rc, kc, lc, fi, li, ld);
        check_output("post_abort_latency", lat, 65);

        run_block(1'b0, 1'b0, 1'b0, lat, rc, kc, lc, fi, li, ld);
        check_output("hold_latency", lat, 65);
        bus.req_valid = 1'b1;
        ov = 0;
        rr = 0;
        repeat (10) begin
            @(negedge clk);
            ov += int'(bus.out_valid);
            rr += int'(bus.req_ready);
        end
        check_output("hold_out_valid_cycles", ov, 10);
        check_output("hold_not_accepted", rr, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_output("release_idle", {bus.req_ready, bus.out_valid}, 2'b10);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_output("next_accept_load", bus.load_block, 1);

        repeat (12) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_output("async_reset_outputs", 32'(dut_vec()), 32'h4000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_block(1'b0, 1'b0, 1'b1, lat, rc, kc, lc, fi, li, ld);
        check_output("post_reset_latency", lat, 65);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
